id_ex_stage: RTL and testbench

//  ID/EX pipeline register and operand-select stage of the 5-stage RV32I core.

---
 rtl/id_ex_if.sv | 53 +++++
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_if.sv
// Bundle of ID-side inputs, forwarding sources and EX-side outputs of the ID/EX stage.
interface id_ex_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned ALUOP_W = 4
);
    logic               flush;
    logic               ex_hold;
    logic               id_valid;
    logic [RA_W-1:0]    id_rs1;
    logic [RA_W-1:0]    id_rs2;
    logic [RA_W-1:0]    id_rd;
    logic [XLEN-1:0]    id_rs1_data;
    logic [XLEN-1:0]    id_rs2_data;
    logic [XLEN-1:0]    id_imm;
    logic               id_use_imm;
    logic [ALUOP_W-1:0] id_alu_op;
    logic               id_reg_write;
    logic               id_mem_read;
    logic               id_mem_write;
    logic [RA_W-1:0]    exmem_rd;
    logic               exmem_wr;
    logic [XLEN-1:0]    exmem_result;
    logic [RA_W-1:0]    memwb_rd;
    logic               memwb_wr;
    logic [XLEN-1:0]    memwb_result;
    logic               id_stall;
    logic               ex_valid;
    logic [XLEN-1:0]    ex_A;
    logic [XLEN-1:0]    ex_B;
    logic [ALUOP_W-1:0] ex_ALUopT;
    logic [XLEN-1:0]    ex_store_data;
    logic [RA_W-1:0]    ex_rd;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic               ex_mem_write;

    modport master (
        output flush, ex_hold, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               exmem_rd, exmem_wr, exmem_result, memwb_rd, memwb_wr, memwb_result,
        input  id_stall, ex_valid, ex_A, ex_B, ex_ALUopT, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  flush, ex_hold, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               exmem_rd, exmem_wr, exmem_result, memwb_rd, memwb_wr, memwb_result,
        output id_stall, ex_valid, ex_A, ex_B, ex_ALUopT, ex_store_data, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use detection, flush and hold.
module id_ex_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    id_ex_if.slave  stage_if
);
    localparam logic [RA_W-1:0] X0 = RA_W'(0);

    logic               valid_q,     valid_d;
    logic [RA_W-1:0]    rs1_q,       rs1_d;
    logic [RA_W-1:0]    rs2_q,       rs2_d;
    logic [RA_W-1:0]    rd_q,        rd_d;
    logic [XLEN-1:0]    rs1_data_q,  rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q,  rs2_data_d;
    logic [XLEN-1:0]    imm_q,       imm_d;
    logic               use_imm_q,   use_imm_d;
    logic [ALUOP_W-1:0] alu_op_q,    alu_op_d;
    logic               reg_write_q, reg_write_d;
    logic               mem_read_q,  mem_read_d;
    logic               mem_write_q, mem_write_d;

    logic [XLEN-1:0]    fwd_rs1, fwd_rs2;
    logic [XLEN-1:0]    cap_rs1, cap_rs2;
    logic               lu;

    // EX forwarding: EX/MEM overrides MEM/WB; x0 never forwarded
    always_comb begin
        fwd_rs1 = rs1_data_q;
        fwd_rs2 = rs2_data_q;
        if (stage_if.memwb_wr && stage_if.memwb_rd != X0 && stage_if.memwb_rd == rs1_q)
            fwd_rs1 = stage_if.memwb_result;
        if (stage_if.exmem_wr && stage_if.exmem_rd != X0 && stage_if.exmem_rd == rs1_q)
            fwd_rs1 = stage_if.exmem_result;
        if (stage_if.memwb_wr && stage_if.memwb_rd != X0 && stage_if.memwb_rd == rs2_q)
            fwd_rs2 = stage_if.memwb_result;
        if (stage_if.exmem_wr && stage_if.exmem_rd != X0 && stage_if.exmem_rd == rs2_q)
            fwd_rs2 = stage_if.exmem_result;
    end

    // Write-back bypass at capture covers the register file's same-cycle write
    always_comb begin
        cap_rs1 = stage_if.id_rs1_data;
        cap_rs2 = stage_if.id_rs2_data;
        if (stage_if.memwb_wr && stage_if.memwb_rd != X0 && stage_if.memwb_rd == stage_if.id_rs1)
            cap_rs1 = stage_if.memwb_result;
        if (stage_if.memwb_wr && stage_if.memwb_rd != X0 && stage_if.memwb_rd == stage_if.id_rs2)
            cap_rs2 = stage_if.memwb_result;
    end

    // rs2 only matters for a load-use if it is actually read (register B operand or store data)
    assign lu = stage_if.id_valid && valid_q && mem_read_q && (rd_q != X0) &&
                ((rd_q == stage_if.id_rs1) ||
                 ((rd_q == stage_if.id_rs2) && (!stage_if.id_use_imm || stage_if.id_mem_write)));

    always_comb begin
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        alu_op_d    = alu_op_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (stage_if.flush || (!stage_if.ex_hold && lu)) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (stage_if.ex_hold) begin
            // keep forwarded data alive after its producer retires during the stall
            rs1_data_d  = fwd_rs1;
            rs2_data_d  = fwd_rs2;
        end else begin
            valid_d     = stage_if.id_valid;
            rs1_d       = stage_if.id_rs1;
            rs2_d       = stage_if.id_rs2;
            rd_d        = stage_if.id_rd;
            rs1_data_d  = cap_rs1;
            rs2_data_d  = cap_rs2;
            imm_d       = stage_if.id_imm;
            use_imm_d   = stage_if.id_use_imm;
            alu_op_d    = stage_if.id_alu_op;
            reg_write_d = stage_if.id_reg_write & stage_if.id_valid;
            mem_read_d  = stage_if.id_mem_read  & stage_if.id_valid;
            mem_write_d = stage_if.id_mem_write & stage_if.id_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            alu_op_q    <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            alu_op_q    <= alu_op_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign stage_if.id_stall      = !stage_if.flush && (stage_if.ex_hold || lu);
    assign stage_if.ex_valid      = valid_q;
    assign stage_if.ex_A          = fwd_rs1;
    assign stage_if.ex_B          = use_imm_q ? imm_q : fwd_rs2;
    assign stage_if.ex_store_data = fwd_rs2;
    assign stage_if.ex_ALUopT     = alu_op_q;
    assign stage_if.ex_rd         = rd_q;
    assign stage_if.ex_reg_write  = reg_write_q;
    assign stage_if.ex_mem_read   = mem_read_q;
    assign stage_if.ex_mem_write  = mem_write_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed pipeline scenarios plus randomized traffic.
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    id_ex_if bus ();

    id_ex_stage dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stage_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference view of the instruction sitting in EX
    logic        m_valid, m_use_imm, m_rw, m_mr, m_mw;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_v1, m_v2, m_imm;
    logic [3:0]  m_op;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Newest value of register r as seen by EX: youngest in-flight producer first
    function automatic logic [31:0] newest(input logic [4:0] r, input logic [31:0] stored);
        logic [4:0]  p_rd  [2];
        logic        p_wr  [2];
        logic [31:0] p_val [2];
        p_rd[0] = bus.exmem_rd; p_wr[0] = bus.exmem_wr; p_val[0] = bus.exmem_result;
        p_rd[1] = bus.memwb_rd; p_wr[1] = bus.memwb_wr; p_val[1] = bus.memwb_result;
        if (r == 5'd0) return stored;
        for (int i = 0; i < 2; i++)
            if (p_wr[i] && p_rd[i] == r) return p_val[i];
        return stored;
    endfunction

    function automatic logic [31:0] regfile_read(input logic [4:0] r, input logic [31:0] d);
        if (r != 5'd0 && bus.memwb_wr && bus.memwb_rd == r) return bus.memwb_result;
        return d;
    endfunction

    function automatic bit model_lu();
        bit reads_rs2;
        reads_rs2 = !bus.id_use_imm || bus.id_mem_write;
        return bus.id_valid && m_valid && m_mr && m_rd != 5'd0 &&
               (m_rd == bus.id_rs1 || (reads_rs2 && m_rd == bus.id_rs2));
    endfunction

    task automatic model_clear();
        m_valid = 0; m_use_imm = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_v1 = 0; m_v2 = 0; m_imm = 0; m_op = 0;
    endtask

    // Compare every observable output with the model
    task automatic eval();
        logic [31:0] a, s;
        bit stall;
        #1;
        stall = !bus.flush && (bus.ex_hold || model_lu());
        check_eq("id_stall",     32'(bus.id_stall),     32'(stall));
        check_eq("ex_valid",     32'(bus.ex_valid),     32'(m_valid));
        check_eq("ex_reg_write", 32'(bus.ex_reg_write), 32'(m_rw));
        check_eq("ex_mem_read",  32'(bus.ex_mem_read),  32'(m_mr));
        check_eq("ex_mem_write", 32'(bus.ex_mem_write), 32'(m_mw));
        if (m_valid) begin
            a = newest(m_rs1, m_v1);
            s = newest(m_rs2, m_v2);
            check_eq("ex_rd",         32'(bus.ex_rd),     32'(m_rd));
            check_eq("ex_ALUopT",     32'(bus.ex_ALUopT), 32'(m_op));
            check_eq("ex_A",          bus.ex_A,           a);
            check_eq("ex_B",          bus.ex_B,           m_use_imm ? m_imm : s);
            check_eq("ex_store_data", bus.ex_store_data,  s);
        end
    endtask

    // Apply one clock edge to the model, then move to the next negedge
    task automatic advance();
        logic [31:0] f1, f2;
        bit lu;
        f1 = newest(m_rs1, m_v1);
        f2 = newest(m_rs2, m_v2);
        lu = model_lu();
        if (bus.flush || (!bus.ex_hold && lu)) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end else if (bus.ex_hold) begin
            m_v1 = f1; m_v2 = f2;
        end else begin
            m_valid = bus.id_valid;
            m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2; m_rd = bus.id_rd;
            m_v1 = regfile_read(bus.id_rs1, bus.id_rs1_data);
            m_v2 = regfile_read(bus.id_rs2, bus.id_rs2_data);
            m_imm = bus.id_imm; m_use_imm = bus.id_use_imm; m_op = bus.id_alu_op;
            m_rw = bus.id_reg_write & bus.id_valid;
            m_mr = bus.id_mem_read  & bus.id_valid;
            m_mw = bus.id_mem_write & bus.id_valid;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic use_imm, input logic [3:0] op,
                          input logic rw, input logic mr, input logic mw);
        bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
        bus.id_use_imm = use_imm; bus.id_alu_op = op;
        bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    endtask

    task automatic set_fwd(input logic [4:0] erd, input logic ewr, input logic [31:0] eres,
                           input logic [4:0] wrd, input logic wwr, input logic [31:0] wres);
        bus.exmem_rd = erd; bus.exmem_wr = ewr; bus.exmem_result = eres;
        bus.memwb_rd = wrd; bus.memwb_wr = wwr; bus.memwb_result = wres;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.flush = 0; bus.ex_hold = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(negedge clk);
        eval();
        check_eq("reset_ex_A", bus.ex_A, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // EX/MEM beats MEM/WB; rd=0 in EX/MEM falls back to the captured value
        set_id(1, 1, 2, 3, 32'h111, 32'h222, 0, 0, 4'b0000, 1, 0, 0);
        eval(); advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(1, 1, 32'h10, 1, 1, 32'h20);
        eval();
        check_eq("fwd_exmem_wins", bus.ex_A, 32'h10);
        set_fwd(0, 1, 32'h10, 1, 0, 32'h20);
        eval();
        check_eq("fwd_rd0_captured", bus.ex_A, 32'h111);
        set_fwd(0, 0, 0, 0, 0, 0);
        advance();

        // lw x5 followed by addi x6,x5,4: one stall, a bubble, then MEM/WB forward
        set_id(1, 1, 0, 5, 32'h100, 0, 32'h8, 1, 4'b0000, 1, 1, 0);
        eval(); advance();
        set_id(1, 5, 0, 6, 32'h5555, 0, 32'h4, 1, 4'b0000, 1, 0, 0);
        eval();
        check_eq("lu_stall", 32'(bus.id_stall), 32'h1);
        advance();
        set_fwd(5, 1, 32'h108, 0, 0, 0);
        eval();
        check_eq("lu_bubble_valid", 32'(bus.ex_valid), 32'h0);
        check_eq("lu_stall_release", 32'(bus.id_stall), 32'h0);
        advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 5, 1, 32'hDEAD);
        eval();
        check_eq("lu_addi_valid", 32'(bus.ex_valid), 32'h1);
        check_eq("lu_addi_A", bus.ex_A, 32'hDEAD);
        set_fwd(0, 0, 0, 0, 0, 0);
        advance();

        // flush dominates hold and load-use
        set_id(1, 1, 0, 5, 32'h100, 0, 32'h8, 1, 4'b0000, 1, 1, 0);
        eval(); advance();
        set_id(1, 5, 0, 6, 0, 0, 32'h4, 1, 4'b0000, 1, 0, 0);
        bus.flush = 1; bus.ex_hold = 1;
        eval();
        check_eq("flush_stall", 32'(bus.id_stall), 32'h0);
        advance();
        bus.flush = 0; bus.ex_hold = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        check_eq("flush_valid", 32'(bus.ex_valid), 32'h0);
        check_eq("flush_rw", 32'(bus.ex_reg_write), 32'h0);
        check_eq("flush_stall_after", 32'(bus.id_stall), 32'h0);
        advance();

        // store held while its rs2 producer drains out of the pipe
        set_id(1, 1, 9, 0, 32'h40, 32'h0, 32'hC, 1, 4'b0000, 0, 0, 1);
        eval(); advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.ex_hold = 1;
        set_fwd(9, 1, 32'hABCD, 0, 0, 0);
        eval(); check_eq("hold_sd_0", bus.ex_store_data, 32'hABCD); advance();
        set_fwd(0, 0, 0, 9, 1, 32'hABCD);
        eval(); check_eq("hold_sd_1", bus.ex_store_data, 32'hABCD); advance();
        set_fwd(0, 0, 0, 0, 0, 0);
        eval(); check_eq("hold_sd_2", bus.ex_store_data, 32'hABCD); advance();
        bus.ex_hold = 0;
        eval(); check_eq("hold_sd_3", bus.ex_store_data, 32'hABCD); advance();

        // lui x7,0x12345
        set_id(1, 0, 0, 7, 32'h0, 32'h0, 32'h12345000, 1, 4'b1111, 1, 0, 0);
        eval(); advance();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        eval();
        check_eq("lui_B", bus.ex_B, 32'h12345000);
        check_eq("lui_op", 32'(bus.ex_ALUopT), 32'hF);
        advance();

        // randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            bus.flush   = ($urandom_range(0, 9) == 0);
            bus.ex_hold = ($urandom_range(0, 5) == 0);
            set_id(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'($urandom),
                   4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            set_fwd(5'($urandom_range(0, 3)), 1'($urandom), $urandom,
                    5'($urandom_range(0, 3)), 1'($urandom), $urandom);
            eval();
            advance();
        end

        // asynchronous reset while EX holds a valid instruction
        bus.flush = 0; bus.ex_hold = 0;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 2, 3, 32'h77, 32'h88, 32'h99, 1, 4'b0110, 1, 0, 0);
        eval(); advance();
        check_eq("pre_reset_valid", 32'(bus.ex_valid), 32'h1);
        set_fwd(1, 1, 32'h1234, 2, 1, 32'h5678);
        #2 rst_n = 1'b0;
        model_clear();
        eval();
        check_eq("rst_ex_A", bus.ex_A, 32'h0);
        check_eq("rst_ex_B", bus.ex_B, 32'h0);
        check_eq("rst_op", 32'(bus.ex_ALUopT), 32'h0);
        check_eq("rst_stall", 32'(bus.id_stall), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        eval();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
